// File: rtl/win_out_sched_if.sv
// win_out_sched_if
//   Bundles the two streaming handshakes of the Winograd output scheduler.
//   The request side carries 4x4 product tiles from the multiply lanes.
//   The result side carries transformed 2x2 tiles to the feature-map writer.
//   Signals:
//     req_valid  [NUM_REQ]      lane i holds a tile
//     req_data   [NUM_REQ*512]  lane i tile {row1,row2,row3,row4}, row1 in MSBs
//     req_ready  [NUM_REQ]      one-hot accept pulse
//     out_valid / out_ready     result handshake
//     out_data   [128]          {f2_2,f2_1,f1_2,f1_1}
//     out_tile_x / out_tile_y   tile coordinates (4 bits each)
//     out_src    [3]            lane that supplied the tile
//   Modports: master = lanes + sink (testbench side), slave = scheduler.
interface win_out_sched_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*512-1:0] req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [127:0]           out_data;
  logic [3:0]             out_tile_x;
  logic [3:0]             out_tile_y;
  logic [2:0]             out_src;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_tile_x, out_tile_y, out_src
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_tile_x, out_tile_y, out_src
  );
endinterface

// File: rtl/win_out_sched.sv
// win_out_sched
//   Sequencer/arbiter for the Winograd F(2x2,3x3) output-transform unit.
//   Accepts one 4x4 product tile at a time from NUM_REQ lanes (round-robin),
//   launches the transform, captures its 2x2 result and streams it out tagged
//   with tile (x,y) and the source lane. One tile is in flight at a time.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             pulse: begin a frame of TILES_X*TILES_Y tiles
//     bus (slave)       request and result handshakes, see win_out_sched_if
//     xf_enable         one-cycle launch strobe to the transform
//     xf_m_tmp1..4      operand rows, held from launch until capture
//     xf_f_tmp          transform result
//     xf_end_signal     transform completion strobe
//     busy              frame in progress (any state but IDLE)
//     done              one-cycle pulse after the last tile is accepted
//     err               sticky watchdog error
//   Build option: define WIN_SCHED_WDOG_EN to build a WAIT-state watchdog of
//   WDOG_CYC cycles (counted from launch) that aborts the frame and sets err.
//   Without it, err is tied low and WAIT waits indefinitely.
module win_out_sched #(
  parameter int NUM_REQ = 2,
  parameter int TILES_X = 14,
  parameter int TILES_Y = 14
`ifdef WIN_SCHED_WDOG_EN
  ,
  parameter int WDOG_CYC = 15
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  win_out_sched_if.slave bus,
  output logic           xf_enable,
  output logic [127:0]   xf_m_tmp1,
  output logic [127:0]   xf_m_tmp2,
  output logic [127:0]   xf_m_tmp3,
  output logic [127:0]   xf_m_tmp4,
  input  logic [127:0]   xf_f_tmp,
  input  logic           xf_end_signal,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t     state_r;
  logic [2:0] rr_r;
  logic [3:0] tile_x_r;
  logic [3:0] tile_y_r;
  logic [7:0] valid8_s;
  logic [3:0] cand_s;
  logic       grant_found_s;
  logic [2:0] grant_idx_s;
  logic       last_tile_s;
`ifdef WIN_SCHED_WDOG_EN
  logic [4:0] wdog_r;
`endif

  assign bus.out_tile_x = tile_x_r;
  assign bus.out_tile_y = tile_y_r;
  assign last_tile_s    = (tile_x_r == 4'(TILES_X - 1)) && (tile_y_r == 4'(TILES_Y - 1));

  // Round-robin search: first valid lane strictly after the last grant, wrapping.
  always_comb begin
    valid8_s      = 8'(bus.req_valid);
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    cand_s        = 4'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = 4'(rr_r) + 4'(k);
      if (cand_s >= 4'(NUM_REQ)) begin
        cand_s = cand_s - 4'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && valid8_s[cand_s[2:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[2:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Accept pulse is combinational so it coincides with the cycle the tile is copied.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_r == S_ARB) && grant_found_s && (grant_idx_s == 3'(i))) begin
        bus.req_ready[i] = 1'b1;
      end else begin
        bus.req_ready[i] = 1'b0;
      end
    end
  end

  // Main sequencer: state, operand/result registers, tile counters and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      rr_r          <= 3'(NUM_REQ - 1);
      tile_x_r      <= 4'd0;
      tile_y_r      <= 4'd0;
      xf_enable     <= 1'b0;
      xf_m_tmp1     <= 128'd0;
      xf_m_tmp2     <= 128'd0;
      xf_m_tmp3     <= 128'd0;
      xf_m_tmp4     <= 128'd0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 128'd0;
      bus.out_src   <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef WIN_SCHED_WDOG_EN
      wdog_r        <= 5'd0;
      err           <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_ARB;
            busy    <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ARB: begin
          if (grant_found_s) begin
            xf_m_tmp1   <= bus.req_data[int'(grant_idx_s)*512 + 384 +: 128];
            xf_m_tmp2   <= bus.req_data[int'(grant_idx_s)*512 + 256 +: 128];
            xf_m_tmp3   <= bus.req_data[int'(grant_idx_s)*512 + 128 +: 128];
            xf_m_tmp4   <= bus.req_data[int'(grant_idx_s)*512 +: 128];
            bus.out_src <= grant_idx_s;
            rr_r        <= grant_idx_s;
            xf_enable   <= 1'b1;
            state_r     <= S_LAUNCH;
          end else begin
            state_r <= S_ARB;
          end
        end
        S_LAUNCH: begin
          xf_enable <= 1'b0;
          state_r   <= S_WAIT;
`ifdef WIN_SCHED_WDOG_EN
          // The launch cycle counts as the first watched cycle.
          wdog_r    <= 5'd1;
`endif
        end
        S_WAIT: begin
          if (xf_end_signal) begin
            bus.out_data  <= xf_f_tmp;
            bus.out_valid <= 1'b1;
            state_r       <= S_OUT;
          end
`ifdef WIN_SCHED_WDOG_EN
          else if (wdog_r == 5'(WDOG_CYC - 1)) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            tile_x_r <= 4'd0;
            tile_y_r <= 4'd0;
            state_r  <= S_IDLE;
          end else begin
            wdog_r <= wdog_r + 5'd1;
          end
`else
          else begin
            state_r <= S_WAIT;
          end
`endif
        end
        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (last_tile_s) begin
              tile_x_r <= 4'd0;
              tile_y_r <= 4'd0;
              done     <= 1'b1;
              state_r  <= S_DONE;
            end else if (tile_x_r == 4'(TILES_X - 1)) begin
              tile_x_r <= 4'd0;
              tile_y_r <= tile_y_r + 4'd1;
              state_r  <= S_ARB;
            end else begin
              tile_x_r <= tile_x_r + 4'd1;
              state_r  <= S_ARB;
            end
          end else begin
            state_r <= S_OUT;
          end
        end
        S_DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          tile_x_r <= 4'd0;
          tile_y_r <= 4'd0;
          state_r  <= S_IDLE;
        end
        default: begin
          xf_enable     <= 1'b0;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

`ifndef WIN_SCHED_WDOG_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_win_out_sched.sv
// tb_win_out_sched
//   Scoreboard bench for win_out_sched with a behavioural transform stub.
//   Stimulus: directed tile patterns with hand-computed 2x2 results.
//   Each accepted tile pushes its expected result; a monitor pops on handshake.
`timescale 1ns/1ps
module tb_win_out_sched;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic xf_enable, xf_end_signal, busy, done, err;
  logic [127:0] xf_m_tmp1, xf_m_tmp2, xf_m_tmp3, xf_m_tmp4, xf_f_tmp;

  always #5 clk = ~clk;

  win_out_sched_if #(.NUM_REQ(NR)) bus ();

  win_out_sched #(.NUM_REQ(NR), .TILES_X(14), .TILES_Y(14)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .xf_enable(xf_enable), .xf_m_tmp1(xf_m_tmp1), .xf_m_tmp2(xf_m_tmp2),
    .xf_m_tmp3(xf_m_tmp3), .xf_m_tmp4(xf_m_tmp4), .xf_f_tmp(xf_f_tmp),
    .xf_end_signal(xf_end_signal), .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transform stub: enable -> end_signal 3 cycles later ----------
  logic [1:0]   stg;
  logic [127:0] f_reg;
  logic         end_sig;
  logic         stub_mute = 1'b0;

  function automatic logic [127:0] wino(input logic [127:0] r0, input logic [127:0] r1,
                                        input logic [127:0] r2, input logic [127:0] r3);
    logic signed [31:0] t0 [4];
    logic signed [31:0] t1 [4];
    logic signed [31:0] f11, f12, f21, f22;
    for (int j = 0; j < 4; j++) begin
      t0[j] = r0[127-32*j -: 32] + r1[127-32*j -: 32] + r2[127-32*j -: 32];
      t1[j] = r1[127-32*j -: 32] - r2[127-32*j -: 32] - r3[127-32*j -: 32];
    end
    f11 = t0[0] + t0[1] + t0[2];
    f12 = t0[1] - t0[2] - t0[3];
    f21 = t1[0] + t1[1] + t1[2];
    f22 = t1[1] - t1[2] - t1[3];
    return {f22, f21, f12, f11};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      stg     <= 2'd0;
      f_reg   <= 128'd0;
      end_sig <= 1'b0;
    end else begin
      if (xf_enable) stg <= 2'd1;
      else if (stg == 2'd1 || stg == 2'd2) stg <= stg + 2'd1;
      else stg <= 2'd0;
      if (stg == 2'd1) f_reg <= wino(xf_m_tmp1, xf_m_tmp2, xf_m_tmp3, xf_m_tmp4);
      end_sig <= (stg == 2'd2) && !stub_mute;
    end
  end
  assign xf_f_tmp      = f_reg;
  assign xf_end_signal = end_sig;

  // ---------------- patterns (hand-computed results) ----------------
  logic [511:0] pat_data [5];
  logic [127:0] pat_exp  [5];
  int           pidx     [NR];

  typedef struct {
    logic [127:0] data;
    logic [3:0]   x;
    logic [3:0]   y;
    logic [2:0]   src;
    logic         last;
  } exp_t;
  exp_t sb [$];

  // shared between processes
  logic rotate = 1'b0;
  logic stall_mode = 1'b0;
  int   upd_seq = 0;
  int   upd_lane = 0;
  int   done_cnt = 0;
  int   res_cnt = 0;

  // ---------------- driver: lane data refresh and out_ready pattern ----------------
  initial begin
    int upd_seen;
    int cyc;
    int stall_left;
    logic stalled_once;
    upd_seen = 0; cyc = 0; stall_left = 0; stalled_once = 1'b0;
    for (int p = 0; p < 5; p++) pat_data[p] = 512'd0;
    for (int i = 0; i < 16; i++) pat_data[0][i*32 +: 32] = 32'd1;
    pat_data[1][511:480] = 32'd5;
    pat_data[2][31:0]    = 32'd7;
    pat_data[3][351:320] = 32'd2;
    pat_data[4][191:160] = 32'hFFFF_FFFF;
    pat_exp[0] = {32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd9};
    pat_exp[1] = {96'd0, 32'd5};
    pat_exp[2] = {32'd7, 96'd0};
    pat_exp[3] = {32'd2, 32'd2, 32'd2, 32'd2};
    pat_exp[4] = {32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF};
    for (int l = 0; l < NR; l++) begin
      pidx[l] = 0;
      bus.req_data[l*512 +: 512] = pat_data[0];
    end
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (upd_seq != upd_seen) begin
        upd_seen = upd_seq;
        if (rotate) pidx[upd_lane] = (pidx[upd_lane] + 1) % 5;
        bus.req_data[upd_lane*512 +: 512] = pat_data[pidx[upd_lane]];
      end
      if (stall_left > 0) begin
        stall_left--;
        bus.out_ready = 1'b0;
      end else if (stall_mode && !stalled_once && bus.out_valid) begin
        stalled_once  = 1'b1;
        stall_left    = 9;
        bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = stall_mode ? ((cyc % 3) != 0) : 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    int exp_x, exp_y, exp_rr, lane, mcyc, grant_cyc;
    logic last_hs_prev, hold_valid, out_seen;
    logic [127:0] hold_data;
    logic [10:0]  hold_tag;
    exp_x = 0; exp_y = 0; exp_rr = NR - 1; mcyc = 0; grant_cyc = 0;
    last_hs_prev = 1'b0; hold_valid = 1'b0; out_seen = 1'b1;
    hold_data = 128'd0; hold_tag = 11'd0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (rst) begin
        sb.delete();
        exp_x = 0; exp_y = 0; exp_rr = NR - 1;
        last_hs_prev = 1'b0; hold_valid = 1'b0; out_seen = 1'b1;
      end else begin
        if (done || last_hs_prev) chk("done_pulse", 128'(done), 128'(last_hs_prev));
        if (done) done_cnt++;
        last_hs_prev = 1'b0;
        if (xf_enable) chk("launch_after_grant", 128'(mcyc - grant_cyc), 128'd1);
        if (hold_valid) begin
          chk("hold_valid", 128'(bus.out_valid), 128'd1);
          chk("hold_data", bus.out_data, hold_data);
          chk("hold_tag", 128'({bus.out_tile_y, bus.out_tile_x, bus.out_src}), 128'(hold_tag));
        end
        hold_valid = 1'b0;
        if (|bus.req_ready) begin
          lane = 0;
          for (int k = NR; k >= 1; k--) begin
            if (bus.req_valid[(exp_rr + k) % NR]) lane = (exp_rr + k) % NR;
          end
          chk("grant", 128'(bus.req_ready), 128'(1) << lane);
          e.data = pat_exp[pidx[lane]];
          e.x    = 4'(exp_x);
          e.y    = 4'(exp_y);
          e.src  = 3'(lane);
          e.last = (exp_x == 13) && (exp_y == 13);
          sb.push_back(e);
          exp_rr = lane;
          if (e.last) begin exp_x = 0; exp_y = 0; end
          else if (exp_x == 13) begin exp_x = 0; exp_y++; end
          else exp_x++;
          upd_lane = lane;
          upd_seq++;
          grant_cyc = mcyc;
          out_seen  = 1'b0;
        end
        if (bus.out_valid) begin
          chk("no_ready_in_out", 128'(bus.req_ready), 128'd0);
          chk("busy_in_out", 128'(busy), 128'd1);
          if (!out_seen) begin
            chk("grant_to_valid", 128'(mcyc - grant_cyc), 128'd5);
            out_seen = 1'b1;
          end
          if (bus.out_ready) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_output: got %h with empty scoreboard", bus.out_data);
            end else begin
              e = sb.pop_front();
              chk("out_data", bus.out_data, e.data);
              chk("out_tile", 128'({bus.out_tile_y, bus.out_tile_x}), 128'({e.y, e.x}));
              chk("out_src", 128'(bus.out_src), 128'(e.src));
              res_cnt++;
              last_hs_prev = e.last;
            end
          end else begin
            hold_valid = 1'b1;
            hold_data  = bus.out_data;
            hold_tag   = {bus.out_tile_y, bus.out_tile_x, bus.out_src};
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_xf_enable"}, 128'(xf_enable), 128'd0);
    chk({tag, "_req_ready"}, 128'(bus.req_ready), 128'd0);
    chk({tag, "_out_data"}, bus.out_data, 128'd0);
    chk({tag, "_tiles"}, 128'({bus.out_tile_y, bus.out_tile_x, bus.out_src}), 128'd0);
    chk({tag, "_m_tmp1"}, xf_m_tmp1, 128'd0);
    chk({tag, "_m_tmp4"}, xf_m_tmp4, 128'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_done_count"}, 128'(done_cnt - d0), 128'd1);
    chk({nm, "_idle_after"}, 128'(busy), 128'd0);
  endtask

  task automatic wait_launch(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (xf_enable) begin seen = 1'b1; break; end
    end
    chk({nm, "_launch_seen"}, 128'(seen), 128'd1);
  endtask

  initial begin
    int r0, d0;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset_err", 128'(err), 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Frame 1: one lane, all-ones tiles; a start pulse mid-frame must be ignored.
    rotate = 1'b0;
    bus.req_valid = 2'b01;
    r0 = res_cnt;
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (res_cnt - r0 >= 50) break;
    end
    pulse_start();
    @(negedge clk);
    chk("start_ignored_busy", 128'(busy), 128'd1);
    wait_done("frame1", 3000);
    chk("frame1_results", 128'(res_cnt - r0), 128'd196);

    // Frame 2: both lanes, rotating patterns, back-pressure including a 10-cycle stall.
    rotate = 1'b1;
    stall_mode = 1'b1;
    bus.req_valid = 2'b11;
    r0 = res_cnt;
    pulse_start();
    wait_done("frame2", 5000);
    chk("frame2_results", 128'(res_cnt - r0), 128'd196);

    // Reset while the transform is running, then a fresh complete frame.
    stall_mode = 1'b0;
    pulse_start();
    wait_launch("midrst");
    @(posedge clk); #1 rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    check_idle("midrst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", 128'(done_cnt - d0), 128'd0);
    r0 = res_cnt;
    pulse_start();
    wait_done("frame3", 3000);
    chk("frame3_results", 128'(res_cnt - r0), 128'd196);

`ifdef WIN_SCHED_WDOG_EN
    // Watchdog: the stub never completes; err must rise 15 cycles after launch.
    begin
      int cnt;
      stub_mute = 1'b1;
      d0 = done_cnt;
      r0 = res_cnt;
      pulse_start();
      wait_launch("wdog");
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        cnt++;
        if (err) break;
      end
      chk("wdog_latency", 128'(cnt), 128'd15);
      chk("wdog_busy", 128'(busy), 128'd0);
      repeat (20) @(negedge clk);
      chk("wdog_no_done", 128'(done_cnt - d0), 128'd0);
      chk("wdog_no_output", 128'(res_cnt - r0), 128'd0);
      chk("wdog_sticky", 128'(err), 128'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      stub_mute = 1'b0;
      @(negedge clk);
      chk("wdog_cleared", 128'(err), 128'd0);
    end
`else
    chk("err_tied_low", 128'(err), 128'd0);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
